// File: rtl/bnn_seq_ctrl.sv
// Program sequencer for the BNN core: fetches 16-bit instructions, runs scalar ops on a
// local register file and hands core ops to the datapath over a valid/ready handshake.
module bnn_seq_ctrl #(
    parameter int PC_W   = 10,
    parameter int NREG   = 4,
    parameter int LOOP_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [PC_W-1:0] start_pc,
    output logic            imem_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    output logic            cmd_valid,
    input  logic            cmd_ready,
    output logic [4:0]      cmd_op,
    output logic [10:0]     cmd_arg,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            flag
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_ISSUE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    // Sized for the widest index field; entries at or above NREG are never written.
    logic [15:0]     regs [8];

    logic [4:0]      op_s;
    logic [2:0]      ri_s;
    logic [7:0]      imm_s;
    logic            reg_ok_s;
    logic [15:0]     rv_s;
    logic [15:0]     dec_s;
    logic [PC_W-1:0] pc_inc_s;
    logic [PC_W-1:0] exec_pc_s;
    logic            wr_en_s;
    logic [15:0]     wr_val_s;
    logic            flag_nxt_s;
    logic            err_set_s;
    logic            is_core_s;
    logic            is_halt_s;

    // Decode the instruction presented in EXEC and compute its effects.
    always_comb begin
        op_s       = imem_data[15:11];
        ri_s       = imem_data[10:8];
        imm_s      = imem_data[7:0];
        reg_ok_s   = ({1'b0, ri_s} < 4'(NREG));
        rv_s       = regs[ri_s];
        dec_s      = rv_s - 16'd1;
        pc_inc_s   = pc + PC_W'(1);
        exec_pc_s  = pc_inc_s;
        wr_en_s    = 1'b0;
        wr_val_s   = rv_s;
        flag_nxt_s = flag;
        err_set_s  = 1'b0;
        is_core_s  = 1'b0;
        is_halt_s  = 1'b0;
        case (op_s)
            5'b00000: begin
                exec_pc_s = pc_inc_s;
            end
            5'b00001: begin
                wr_en_s   = reg_ok_s;
                wr_val_s  = {rv_s[15:8], imm_s};
                err_set_s = !reg_ok_s;
            end
            5'b00010: begin
                wr_en_s   = reg_ok_s;
                wr_val_s  = {imm_s, rv_s[7:0]};
                err_set_s = !reg_ok_s;
            end
            5'b00100: begin
                wr_en_s   = reg_ok_s;
                wr_val_s  = rv_s + {{8{imm_s[7]}}, imm_s};
                err_set_s = !reg_ok_s;
            end
            5'b00101: begin
                if (reg_ok_s) begin
                    flag_nxt_s = (rv_s > {8'h00, imm_s});
                end else begin
                    err_set_s = 1'b1;
                end
            end
            5'b00110: begin
                if (flag) begin
                    exec_pc_s = pc - PC_W'(imem_data[10:0]);
                end else begin
                    exec_pc_s = pc_inc_s;
                end
            end
            5'b01110: begin
                if (reg_ok_s) begin
                    wr_en_s  = 1'b1;
                    wr_val_s = dec_s;
                    // A zero counter wraps to 0xFFFF and therefore loops again.
                    if (dec_s != 16'd0) begin
                        exec_pc_s = pc - PC_W'(imem_data[LOOP_W-1:0]);
                    end else begin
                        exec_pc_s = pc_inc_s;
                    end
                end else begin
                    err_set_s = 1'b1;
                end
            end
            5'b01111: begin
                is_halt_s = 1'b1;
                exec_pc_s = pc;
            end
            5'b00011, 5'b00111, 5'b01000, 5'b01001,
            5'b01010, 5'b01011, 5'b01100, 5'b01101: begin
                is_core_s = 1'b1;
                exec_pc_s = pc;
            end
            default: begin
                err_set_s = 1'b1;
            end
        endcase
    end

    // Sequencer state machine with registered outputs and register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= '0;
            imem_en   <= 1'b0;
            imem_addr <= '0;
            cmd_valid <= 1'b0;
            cmd_op    <= 5'd0;
            cmd_arg   <= 11'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            flag      <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                regs[k] <= 16'h0000;
            end
        end else begin
            imem_en <= 1'b0;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_FETCH;
                        pc        <= start_pc;
                        imem_en   <= 1'b1;
                        imem_addr <= start_pc;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_FETCH: begin
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (wr_en_s) begin
                        regs[ri_s] <= wr_val_s;
                    end else begin
                        regs[ri_s] <= regs[ri_s];
                    end
                    flag <= flag_nxt_s;
                    err  <= err | err_set_s;
                    pc   <= exec_pc_s;
                    if (is_halt_s) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (is_core_s) begin
                        state     <= S_ISSUE;
                        cmd_valid <= 1'b1;
                        cmd_op    <= op_s;
                        cmd_arg   <= imem_data[10:0];
                    end else begin
                        state     <= S_FETCH;
                        imem_en   <= 1'b1;
                        imem_addr <= exec_pc_s;
                    end
                end
                S_ISSUE: begin
                    if (cmd_valid && cmd_ready) begin
                        state     <= S_FETCH;
                        cmd_valid <= 1'b0;
                        pc        <= pc_inc_s;
                        imem_en   <= 1'b1;
                        imem_addr <= pc_inc_s;
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    cmd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// Directed bench for bnn_seq_ctrl: a small instruction memory model plus per-scenario tasks.
module tb_bnn_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  start_pc = 10'd0;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [15:0] imem_data = 16'h0000;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [4:0]  cmd_op;
    logic [10:0] cmd_arg;
    logic        busy, done, err, flag;

    int total = 0;
    int bad = 0;

    logic [15:0] mem [1024];
    int          hs_cnt = 0;
    logic [4:0]  last_op = 5'd0;
    logic [10:0] last_arg = 11'd0;
    logic [9:0]  trace [256];
    int          tr_n = 0;

    bnn_seq_ctrl #(.PC_W(10), .NREG(4), .LOOP_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .busy(busy), .done(done), .err(err), .flag(flag)
    );

    always #5 clk = ~clk;

    // Instruction SRAM with one-cycle read latency, plus handshake and fetch monitors.
    always @(posedge clk) begin
        if (imem_en) begin
            imem_data <= mem[imem_addr];
            trace[tr_n % 256] <= imem_addr;
            tr_n <= tr_n + 1;
        end
        if (cmd_valid && cmd_ready) begin
            hs_cnt   <= hs_cnt + 1;
            last_op  <= cmd_op;
            last_arg <= cmd_arg;
        end
    end

    function automatic logic [15:0] ri(input logic [4:0] op, input logic [2:0] r, input logic [7:0] imm);
        return {op, r, imm};
    endfunction

    function automatic logic [15:0] rc(input logic [4:0] op, input logic [10:0] arg);
        return {op, arg};
    endfunction

    task automatic clear_mem();
        for (int a = 0; a < 1024; a++) mem[a] = 16'h7800;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start(input logic [9:0] spc);
        @(negedge clk);
        start = 1'b1;
        start_pc = spc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output int cyc, output bit timed_out);
        cyc = 0;
        while (!done && cyc < maxc) begin
            @(negedge clk);
            cyc++;
        end
        timed_out = !done;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({busy, done, err, flag, cmd_valid, imem_en} !== 6'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=000000", {busy, done, err, flag, cmd_valid, imem_en});
        end
        total++;
        if ({imem_addr, cmd_op, cmd_arg} !== 26'd0) begin
            bad++; $display("FAIL reset_buses got=%h exp=0", {imem_addr, cmd_op, cmd_arg});
        end
        total++;
        if (dut.pc !== 10'd0) begin
            bad++; $display("FAIL reset_pc got=%h exp=0", dut.pc);
        end
    endtask

    task automatic test_load_halt();
        int cyc;
        bit to;
        do_reset();
        clear_mem();
        mem[5] = ri(5'b00001, 3'd1, 8'h34);
        mem[6] = ri(5'b00010, 3'd1, 8'h12);
        mem[7] = 16'h7800;
        pulse_start(10'd5);
        wait_done(40, cyc, to);
        total++;
        if (to || cyc + 1 != 7) begin
            bad++; $display("FAIL load_done_latency got=%0d exp=7 timeout=%0d", cyc + 1, to);
        end
        total++;
        if (dut.regs[1] !== 16'h1234) begin
            bad++; $display("FAIL load_r1 got=%h exp=1234", dut.regs[1]);
        end
        total++;
        if (dut.pc !== 10'd7) begin
            bad++; $display("FAIL halt_pc got=%h exp=007", dut.pc);
        end
        @(negedge clk);
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++; $display("FAIL after_done busy/done got=%b exp=00", {busy, done});
        end
    endtask

    task automatic test_djnz();
        int cyc, base;
        bit to;
        do_reset();
        clear_mem();
        mem[0] = ri(5'b00001, 3'd2, 8'd3);
        mem[1] = rc(5'b00111, 11'h055);
        mem[2] = ri(5'b01110, 3'd2, 8'd1);
        mem[3] = 16'h7800;
        cmd_ready = 1'b1;
        base = hs_cnt;
        pulse_start(10'd0);
        wait_done(200, cyc, to);
        total++;
        if (to) begin
            bad++; $display("FAIL djnz_timeout got=timeout exp=done");
        end
        total++;
        if (hs_cnt - base != 3) begin
            bad++; $display("FAIL djnz_handshakes got=%0d exp=3", hs_cnt - base);
        end
        total++;
        if ({last_op, last_arg} !== {5'b00111, 11'h055}) begin
            bad++; $display("FAIL djnz_cmd got=%b/%h exp=00111/055", last_op, last_arg);
        end
        total++;
        if (dut.regs[2] !== 16'h0000) begin
            bad++; $display("FAIL djnz_r2 got=%h exp=0000", dut.regs[2]);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int k, cyc;
        bit to;
        do_reset();
        clear_mem();
        mem[0] = rc(5'b00011, 11'h180);
        mem[1] = 16'h7800;
        cmd_ready = 1'b0;
        pulse_start(10'd0);
        k = 0;
        while (!cmd_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (!cmd_valid) begin
            bad++; $display("FAIL bp_valid_timeout got=0 exp=1");
        end
        for (int n = 1; n <= 5; n++) begin
            total++;
            if ({cmd_valid, cmd_op, cmd_arg} !== {1'b1, 5'b00011, 11'h180}) begin
                bad++; $display("FAIL bp_hold cyc=%0d got=%b/%b/%h exp=1/00011/180", n, cmd_valid, cmd_op, cmd_arg);
            end
            total++;
            if (dut.pc !== 10'd0) begin
                bad++; $display("FAIL bp_pc cyc=%0d got=%h exp=000", n, dut.pc);
            end
            // A start pulse while busy must be ignored.
            start = (n == 2);
            start_pc = 10'h3FF;
            cmd_ready = (n == 5);
            @(negedge clk);
        end
        start = 1'b0;
        total++;
        if (cmd_valid !== 1'b0 || dut.pc !== 10'd1) begin
            bad++; $display("FAIL bp_release got=valid %b pc %h exp=valid 0 pc 001", cmd_valid, dut.pc);
        end
        wait_done(40, cyc, to);
        total++;
        if (to || dut.pc !== 10'd1) begin
            bad++; $display("FAIL bp_halt got=pc %h timeout %0d exp=pc 001", dut.pc, to);
        end
        @(negedge clk);
    endtask

    task automatic test_arith();
        int cyc, base;
        bit to;
        logic [9:0] exp_tr [8];
        exp_tr = '{10'd10, 10'd11, 10'd12, 10'd13, 10'd11, 10'd12, 10'd13, 10'd14};
        do_reset();
        clear_mem();
        mem[10] = ri(5'b00100, 3'd0, 8'hFF);
        mem[11] = ri(5'b00101, 3'd0, 8'h10);
        mem[12] = ri(5'b00100, 3'd0, 8'h11);
        mem[13] = rc(5'b00110, 11'd2);
        mem[14] = 16'h7800;
        base = tr_n;
        pulse_start(10'd10);
        wait_done(100, cyc, to);
        total++;
        if (to || tr_n - base != 8) begin
            bad++; $display("FAIL arith_fetch_count got=%0d exp=8 timeout=%0d", tr_n - base, to);
        end
        for (int n = 0; n < 8; n++) begin
            total++;
            if (trace[(base + n) % 256] !== exp_tr[n]) begin
                bad++; $display("FAIL arith_trace idx=%0d got=%0d exp=%0d", n, trace[(base + n) % 256], exp_tr[n]);
            end
        end
        total++;
        if (dut.regs[0] !== 16'h0021 || flag !== 1'b0) begin
            bad++; $display("FAIL arith_final got=r0 %h flag %b exp=r0 0021 flag 0", dut.regs[0], flag);
        end
        @(negedge clk);
    endtask

    task automatic test_error();
        int cyc;
        bit to;
        do_reset();
        clear_mem();
        mem[10'h3FF] = 16'h8123;
        mem[0] = ri(5'b00001, 3'd7, 8'hAA);
        mem[1] = ri(5'b00001, 3'd3, 8'h5A);
        mem[2] = 16'h7800;
        pulse_start(10'h3FF);
        wait_done(60, cyc, to);
        total++;
        if (to || err !== 1'b1) begin
            bad++; $display("FAIL err_set got=%b timeout=%0d exp=1", err, to);
        end
        total++;
        if ({dut.regs[0], dut.regs[1], dut.regs[2], dut.regs[7]} !== 64'd0) begin
            bad++; $display("FAIL err_regs_unchanged got=%h exp=0", {dut.regs[0], dut.regs[1], dut.regs[2], dut.regs[7]});
        end
        total++;
        if (dut.regs[3] !== 16'h005A || dut.pc !== 10'd2) begin
            bad++; $display("FAIL err_continue got=r3 %h pc %h exp=r3 005a pc 002", dut.regs[3], dut.pc);
        end
        @(negedge clk);
        pulse_start(10'd2);
        total++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL err_clear got=err %b busy %b exp=err 0 busy 1", err, busy);
        end
        wait_done(20, cyc, to);
        @(negedge clk);
    endtask

    task automatic test_rst_issue();
        int k, cyc, base;
        bit to;
        do_reset();
        clear_mem();
        mem[0] = rc(5'b01000, 11'h7FF);
        mem[1] = 16'h7800;
        cmd_ready = 1'b0;
        pulse_start(10'd0);
        k = 0;
        while (!cmd_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        total++;
        if (cmd_valid !== 1'b1) begin
            bad++; $display("FAIL rst_pre_valid got=%b exp=1", cmd_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({cmd_valid, busy} !== 2'b00 || dut.pc !== 10'd0) begin
            bad++; $display("FAIL rst_in_issue got=valid %b busy %b pc %h exp=0 0 000", cmd_valid, busy, dut.pc);
        end
        cmd_ready = 1'b1;
        base = hs_cnt;
        pulse_start(10'd0);
        wait_done(40, cyc, to);
        total++;
        if (to || hs_cnt - base != 1 || last_arg !== 11'h7FF || last_op !== 5'b01000) begin
            bad++; $display("FAIL rst_restart got=hs %0d op %b arg %h exp=hs 1 op 01000 arg 7ff", hs_cnt - base, last_op, last_arg);
        end
        total++;
        if (dut.pc !== 10'd1) begin
            bad++; $display("FAIL rst_restart_pc got=%h exp=001", dut.pc);
        end
        @(negedge clk);
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_load_halt();
        test_djnz();
        test_backpressure();
        test_arith();
        test_error();
        test_rst_issue();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
